// File: rtl/lcd_write_field.sv
// Prints a NUM_DIGITS hex number at (row, col) on an HD44780-style LCD by
// sequencing byte/nibble transfers to lcd_display; runs the 4-bit init sequence after reset.
module lcd_write_field #(
  parameter int          NUM_DIGITS = 8,
  parameter logic [31:0] PWRUP_DLY  = 32'd10000000,
  parameter logic [31:0] CLR_DLY    = 32'd1000000,
  parameter logic [31:0] CMD_DLY    = 32'd20000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] if_data,
  input  logic                    if_row,
  input  logic [3:0]              if_col,
  input  logic                    if_blank,
  input  logic                    if_clear,
  input  logic                    if_write,
  output logic                    if_ready,
  output logic [7:0]              disp_data,
  output logic                    disp_rs,
  output logic [31:0]             disp_delay,
  output logic                    disp_b8,
  output logic                    disp_write,
  input  logic                    disp_ready
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);
  localparam logic PH_ISSUE = 1'b0;
  localparam logic PH_WAIT  = 1'b1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CLEAR, S_ADDR, S_DIGIT} state_t;

  state_t          state, state_nx;
  logic            phase, phase_nx;
  logic [1:0]      gap, gap_nx;
  logic [2:0]      step, step_nx;
  logic [CW-1:0]   dcnt, dcnt_nx;
  logic [DW-1:0]   shreg, shreg_nx;
  logic            row_q, row_nx;
  logic [3:0]      col_q, col_nx;
  logic            blank_q, blank_nx;
  logic            lead, lead_nx;
  logic [7:0]      data_nx;
  logic            rs_nx, b8_nx, write_nx;
  logic [31:0]     dly_nx;
  logic            issue, done;
  logic [3:0]      msd;

  assign if_ready = (state == S_IDLE);
  assign msd      = shreg[DW-1 -: 4];
  assign issue    = (phase == PH_ISSUE) && disp_ready;
  // gap covers the pulse cycle and the one after, while lcd_display may still report stale ready
  assign done     = (phase == PH_WAIT) && (gap == 2'd0) && disp_ready;

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    gap_nx   = gap;
    step_nx  = step;
    dcnt_nx  = dcnt;
    shreg_nx = shreg;
    row_nx   = row_q;
    col_nx   = col_q;
    blank_nx = blank_q;
    lead_nx  = lead;
    data_nx  = disp_data;
    rs_nx    = disp_rs;
    b8_nx    = disp_b8;
    dly_nx   = disp_delay;
    write_nx = 1'b0;

    if (phase == PH_WAIT && gap != 2'd0) gap_nx = gap - 2'd1;

    if (issue && state != S_IDLE) begin
      write_nx = 1'b1;
      phase_nx = PH_WAIT;
      gap_nx   = 2'd2;
      rs_nx    = 1'b0;
      b8_nx    = 1'b1;
      dly_nx   = CMD_DLY;
    end

    case (state)
      S_INIT: begin
        if (issue) begin
          case (step)
            3'd0:    begin data_nx = 8'h30; b8_nx = 1'b0; dly_nx = PWRUP_DLY; end
            3'd1:    begin data_nx = 8'h30; b8_nx = 1'b0; end
            3'd2:    begin data_nx = 8'h30; b8_nx = 1'b0; dly_nx = CLR_DLY; end
            3'd3:    begin data_nx = 8'h20; b8_nx = 1'b0; end
            3'd4:    data_nx = 8'h28;
            3'd5:    data_nx = 8'h06;
            3'd6:    data_nx = 8'h0C;
            default: begin data_nx = 8'h01; dly_nx = CLR_DLY; end
          endcase
        end
        if (done) begin
          phase_nx = PH_ISSUE;
          if (step == 3'd7) begin
            state_nx = S_IDLE;
            step_nx  = 3'd0;
          end else begin
            step_nx = step + 3'd1;
          end
        end
      end
      S_IDLE: begin
        if (if_write) begin
          shreg_nx = if_data;
          row_nx   = if_row;
          col_nx   = if_col;
          blank_nx = if_blank;
          lead_nx  = 1'b1;
          dcnt_nx  = '0;
          phase_nx = PH_ISSUE;
          state_nx = if_clear ? S_CLEAR : S_ADDR;
        end
      end
      S_CLEAR: begin
        if (issue) begin
          data_nx = 8'h01;
          dly_nx  = CLR_DLY;
        end
        if (done) begin
          phase_nx = PH_ISSUE;
          state_nx = S_ADDR;
        end
      end
      S_ADDR: begin
        if (issue) data_nx = {1'b1, row_q, 2'b00, col_q};
        if (done) begin
          phase_nx = PH_ISSUE;
          state_nx = S_DIGIT;
          dcnt_nx  = '0;
        end
      end
      S_DIGIT: begin
        if (issue) begin
          rs_nx = 1'b1;
          // the LSD is never blanked so a zero value still shows one '0'
          if (blank_q && lead && msd == 4'h0 && dcnt != LAST) begin
            data_nx = 8'h20;
          end else begin
            lead_nx = 1'b0;
            data_nx = (msd <= 4'd9) ? 8'h30 + {4'h0, msd} : 8'h37 + {4'h0, msd};
          end
          shreg_nx = shreg << 4;
        end
        if (done) begin
          phase_nx = PH_ISSUE;
          if (dcnt == LAST) begin
            state_nx = S_IDLE;
            dcnt_nx  = '0;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      phase      <= PH_ISSUE;
      gap        <= 2'd0;
      step       <= 3'd0;
      dcnt       <= '0;
      shreg      <= '0;
      row_q      <= 1'b0;
      col_q      <= 4'd0;
      blank_q    <= 1'b0;
      lead       <= 1'b0;
      disp_data  <= 8'h00;
      disp_rs    <= 1'b0;
      disp_b8    <= 1'b0;
      disp_delay <= 32'd0;
      disp_write <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      gap        <= gap_nx;
      step       <= step_nx;
      dcnt       <= dcnt_nx;
      shreg      <= shreg_nx;
      row_q      <= row_nx;
      col_q      <= col_nx;
      blank_q    <= blank_nx;
      lead       <= lead_nx;
      disp_data  <= data_nx;
      disp_rs    <= rs_nx;
      disp_b8    <= b8_nx;
      disp_delay <= dly_nx;
      disp_write <= write_nx;
    end
  end

endmodule

// File: tb/tb_lcd_write_field.sv
// Scenario bench for lcd_write_field: 8-digit and 4-digit instances, each with a
// lcd_display ready model that goes busy for 5 cycles after every transfer.
module tb_lcd_write_field;

  localparam logic [31:0] PW = 32'd10000000;
  localparam logic [31:0] CL = 32'd1000000;
  localparam logic [31:0] CM = 32'd20000;

  typedef logic [41:0] xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_data = '0;
  logic [15:0] if_data4 = '0;
  logic        if_row = 1'b0, if_blank = 1'b0, if_clear = 1'b0;
  logic [3:0]  if_col = '0;
  logic        if_write = 1'b0, if_write4 = 1'b0;
  logic        if_ready, if_ready4;
  logic [7:0]  disp_data, disp_data4;
  logic        disp_rs, disp_rs4, disp_b8, disp_b84, disp_write, disp_write4;
  logic [31:0] disp_delay, disp_delay4;
  logic        disp_ready, disp_ready4;
  logic [2:0]  bcnt, bcnt4;

  int    n_cmp = 0;
  int    n_bad = 0;
  xfer_t exp_q[$];

  always #5 clk = ~clk;

  lcd_write_field dut (
    .clk(clk), .rst_n(rst_n), .if_data(if_data), .if_row(if_row), .if_col(if_col),
    .if_blank(if_blank), .if_clear(if_clear), .if_write(if_write), .if_ready(if_ready),
    .disp_data(disp_data), .disp_rs(disp_rs), .disp_delay(disp_delay), .disp_b8(disp_b8),
    .disp_write(disp_write), .disp_ready(disp_ready)
  );

  lcd_write_field #(.NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .if_data(if_data4), .if_row(if_row), .if_col(if_col),
    .if_blank(if_blank), .if_clear(if_clear), .if_write(if_write4), .if_ready(if_ready4),
    .disp_data(disp_data4), .disp_rs(disp_rs4), .disp_delay(disp_delay4), .disp_b8(disp_b84),
    .disp_write(disp_write4), .disp_ready(disp_ready4)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_ready <= 1'b1; bcnt <= 3'd0;
    end else if (disp_write) begin
      disp_ready <= 1'b0; bcnt <= 3'd5;
    end else if (bcnt != 3'd0) begin
      bcnt <= bcnt - 3'd1;
      if (bcnt == 3'd1) disp_ready <= 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_ready4 <= 1'b1; bcnt4 <= 3'd0;
    end else if (disp_write4) begin
      disp_ready4 <= 1'b0; bcnt4 <= 3'd5;
    end else if (bcnt4 != 3'd0) begin
      bcnt4 <= bcnt4 - 3'd1;
      if (bcnt4 == 3'd1) disp_ready4 <= 1'b1;
    end
  end

  function automatic xfer_t mk(input logic [7:0] d, input logic rs, input logic b8,
                               input logic [31:0] dl);
    return {d, rs, b8, dl};
  endfunction

  task automatic push_init();
    exp_q.push_back(mk(8'h30, 0, 0, PW));
    exp_q.push_back(mk(8'h30, 0, 0, CM));
    exp_q.push_back(mk(8'h30, 0, 0, CL));
    exp_q.push_back(mk(8'h20, 0, 0, CM));
    exp_q.push_back(mk(8'h28, 0, 1, CM));
    exp_q.push_back(mk(8'h06, 0, 1, CM));
    exp_q.push_back(mk(8'h0C, 0, 1, CM));
    exp_q.push_back(mk(8'h01, 0, 1, CL));
  endtask

  // Reference model of one write request, pushed as the request is driven
  task automatic push_write(input logic [31:0] data, input int n, input logic row,
                            input logic [3:0] col, input logic blank, input logic clear);
    logic       lead;
    logic [3:0] d;
    logic [7:0] c;
    if (clear) exp_q.push_back(mk(8'h01, 0, 1, CL));
    exp_q.push_back(mk(8'h80 + (row ? 8'h40 : 8'h00) + {4'h0, col}, 0, 1, CM));
    lead = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = data[4*(n-1-i) +: 4];
      if (blank && lead && d == 4'h0 && i != n - 1) begin
        c = 8'h20;
      end else begin
        lead = 1'b0;
        c = (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h41 + {4'h0, d} - 8'd10;
      end
      exp_q.push_back(mk(c, 1, 1, CM));
    end
  endtask

  task automatic get_xfer(input bit w4, output xfer_t x, output bit ok);
    ok = 1'b0;
    x  = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!w4 && disp_write) begin
        x = {disp_data, disp_rs, disp_b8, disp_delay}; ok = 1'b1; break;
      end
      if (w4 && disp_write4) begin
        x = {disp_data4, disp_rs4, disp_b84, disp_delay4}; ok = 1'b1; break;
      end
    end
  endtask

  task automatic wait_ready(input bit w4, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((!w4 && if_ready) || (w4 && if_ready4)) begin
        cyc = i; break;
      end
    end
  endtask

  task automatic count_writes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (disp_write) n++;
    end
  endtask

  task automatic send(input logic [31:0] data, input logic row, input logic [3:0] col,
                      input logic blank, input logic clear);
    @(negedge clk);
    if_data = data; if_row = row; if_col = col; if_blank = blank; if_clear = clear;
    if_write = 1'b1;
    @(negedge clk);
    if_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if_ready, disp_write, disp_data, disp_rs, disp_b8, disp_delay} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b wr=%b d=%h rs=%b b8=%b dl=%0d want all zero",
               if_ready, disp_write, disp_data, disp_rs, disp_b8, disp_delay);
    end
    n_cmp++;
    if ({if_ready4, disp_write4, disp_data4, disp_delay4} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs4 got rdy=%b wr=%b d=%h want all zero",
               if_ready4, disp_write4, disp_data4);
    end
  endtask

  task automatic test_init(input string tag);
    xfer_t x, e;
    bit    ok;
    int    cyc;
    push_init();
    @(negedge clk);
    rst_n = 1'b1;
    while (exp_q.size() > 0) begin
      get_xfer(0, x, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || x !== e) begin
        n_bad++;
        $display("FAIL %s_xfer got %h (seen=%0d) want %h", tag, x, ok, e);
      end
    end
    wait_ready(0, cyc);
    n_cmp++;
    if (cyc !== 7) begin
      n_bad++;
      $display("FAIL %s_ready_latency got %0d cycles want 7", tag, cyc);
    end
  endtask

  task automatic test_write(input string tag, input logic [31:0] data, input logic row,
                            input logic [3:0] col, input logic blank, input logic clear);
    xfer_t x, e;
    bit    ok;
    int    cyc;
    push_write(data, 8, row, col, blank, clear);
    send(data, row, col, blank, clear);
    n_cmp++;
    if (if_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ready_drop got %b want 0", tag, if_ready);
    end
    while (exp_q.size() > 0) begin
      get_xfer(0, x, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || x !== e) begin
        n_bad++;
        $display("FAIL %s_xfer got %h (seen=%0d) want %h", tag, x, ok, e);
      end
    end
    wait_ready(0, cyc);
    n_cmp++;
    if (cyc !== 7) begin
      n_bad++;
      $display("FAIL %s_ready_latency got %0d cycles want 7", tag, cyc);
    end
  endtask

  task automatic test_busy();
    xfer_t x, e;
    bit    ok;
    int    cyc, n;
    push_write(32'h12345678, 8, 1'b0, 4'd2, 1'b0, 1'b0);
    send(32'h12345678, 1'b0, 4'd2, 1'b0, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      get_xfer(0, x, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || x !== e) begin
        n_bad++;
        $display("FAIL busy_xfer got %h (seen=%0d) want %h", x, ok, e);
      end
      if (k == 2) send(32'hFFFFFFFF, 1'b1, 4'd9, 1'b1, 1'b1);
    end
    wait_ready(0, cyc);
    n_cmp++;
    if (cyc == 0) begin
      n_bad++;
      $display("FAIL busy_ready got timeout want if_ready=1");
    end
    count_writes(60, n);
    n_cmp++;
    if (n !== 0) begin
      n_bad++;
      $display("FAIL busy_extra_xfers got %0d want 0", n);
    end
  endtask

  task automatic test_reset_mid();
    xfer_t x;
    bit    ok;
    int    n;
    send(32'h87654321, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) get_xfer(0, x, ok);
    n_cmp++;
    if (!ok || x[41:34] !== 8'h37) begin
      n_bad++;
      $display("FAIL midreset_pre got %h (seen=%0d) want char 37", x[41:34], ok);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (disp_write !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_write_drop got %b want 0", disp_write);
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    test_init("reinit");
    count_writes(60, n);
    n_cmp++;
    if (n !== 0) begin
      n_bad++;
      $display("FAIL midreset_request_lost got %0d xfers want 0", n);
    end
  endtask

  task automatic test_param();
    xfer_t x, e;
    bit    ok;
    int    cyc;
    wait_ready(1, cyc);
    n_cmp++;
    if (cyc == 0) begin
      n_bad++;
      $display("FAIL param_init_ready got timeout want if_ready=1");
    end
    push_write(32'h0000BEEF, 4, 1'b0, 4'd14, 1'b0, 1'b0);
    @(negedge clk);
    if_data4 = 16'hBEEF; if_row = 1'b0; if_col = 4'd14; if_blank = 1'b0; if_clear = 1'b0;
    if_write4 = 1'b1;
    @(negedge clk);
    if_write4 = 1'b0;
    while (exp_q.size() > 0) begin
      get_xfer(1, x, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || x !== e) begin
        n_bad++;
        $display("FAIL param_xfer got %h (seen=%0d) want %h", x, ok, e);
      end
    end
    wait_ready(1, cyc);
    n_cmp++;
    if (cyc !== 7) begin
      n_bad++;
      $display("FAIL param_ready_latency got %0d cycles want 7", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_write("basic", 32'h12ABCDEF, 1'b0, 4'd0, 1'b0, 1'b1);
    test_write("blanked", 32'h000000A5, 1'b1, 4'd4, 1'b1, 1'b0);
    test_write("zero", 32'h00000000, 1'b0, 4'd0, 1'b1, 1'b0);
    test_busy();
    test_reset_mid();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_write_field.md
LCD_WRITE_FIELD -- requirements
Module: lcd_write_field

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, giving the hex digits printed, legal range 1..8.
REQ-002 SHALL have parameter PWRUP_DLY, default 32'd10000000, giving the delay for the first init command.
REQ-003 SHALL have parameter CLR_DLY, default 32'd1000000, giving the delay for the third init command and for every clear.
REQ-004 SHALL have parameter CMD_DLY, default 32'd20000, giving the delay for all other commands and characters.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have port if_data, input, 4*NUM_DIGITS bits: the number to print, MSD first.
REQ-008 SHALL have port if_row, input, 1 bit: the LCD line (0 = top, 1 = bottom).
REQ-009 SHALL have port if_col, input, 4 bits: the start column, 0..15.
REQ-010 SHALL have port if_blank, input, 1 bit: suppress leading zeros.
REQ-011 SHALL have port if_clear, input, 1 bit: clear the display before writing.
REQ-012 SHALL have port if_write, input, 1 bit: request strobe.
REQ-013 SHALL have port if_ready, output, 1 bit: idle, request accepted.
REQ-014 SHALL have port disp_data, output, 8 bits: byte sent to lcd_display.
REQ-015 SHALL have port disp_rs, output, 1 bit: 0 = command, 1 = character.
REQ-016 SHALL have port disp_delay, output, 32 bits: post-transfer wait in clk cycles.
REQ-017 SHALL have port disp_b8, output, 1 bit: 0 = single 4-bit nibble transfer, 1 = full byte.
REQ-018 SHALL have port disp_write, output, 1 bit: transfer strobe.
REQ-019 SHALL have port disp_ready, input, 1 bit: lcd_display idle.

Function
REQ-020 SHALL issue each transfer as follows:
- Issue only when disp_ready=1 in the ISSUE state.
- disp_data, disp_rs, disp_delay and disp_b8 are valid in the cycle disp_write=1 and held until the next issue.
- disp_write is a one-cycle pulse.
- After the pulse: ignore disp_ready for 1 cycle, then wait for disp_ready=1.
REQ-021 SHALL run the init sequence after reset release:
- Bytes 30,30,30,20 with disp_b8=0, then 28,06,0C,01 with disp_b8=1.
- All init transfers use disp_rs=0.
- Delays: 30#1 = PWRUP_DLY, 30#3 = CLR_DLY, 01 = CLR_DLY, all others = CMD_DLY.
REQ-022 SHALL use the states INIT, IDLE, CLEAR, ADDR, DIGIT, each with ISSUE and WAIT sub-phases.
REQ-023 SHALL, when the final init transfer completes (disp_ready=1), enter IDLE and assert if_ready in the next cycle.
REQ-024 SHALL, on if_write=1 with if_ready=1, capture if_data, if_row, if_col, if_blank and if_clear, and drop if_ready in the next cycle.
REQ-025 SHALL ignore if_write while if_ready=0; captured values are unaffected by input changes.
REQ-026 SHALL, if the captured if_clear=1, send 01 (rs 0, b8 1, CLR_DLY), then go to ADDR; otherwise go directly to ADDR.
REQ-027 SHALL, in ADDR, send 0x80 | (row<<6) | col with rs 0, b8 1 and CMD_DLY.
REQ-028 SHALL, in DIGIT, send NUM_DIGITS characters MSD first with rs 1, b8 1 and CMD_DLY.
REQ-029 SHALL encode each digit d as ASCII: d<=9 gives 0x30+d; d>=10 gives 0x37+d.
REQ-030 SHALL, with blank=1, send 0x20 for each zero digit preceding the first nonzero digit.
REQ-031 SHALL always print the LSD, so a value of 0 shows a single '0'.
REQ-032 SHALL NOT re-address when col+NUM_DIGITS exceeds 16; the overflow characters are sent unchanged.
REQ-033 SHALL count digits with a counter of width $clog2(NUM_DIGITS+1), with no wrap before NUM_DIGITS.
REQ-034 SHALL assert if_ready in the cycle after the last character's WAIT sees disp_ready=1, then return to IDLE.

Reset
REQ-035 SHALL, while rst_n=0, hold these output values:
- if_ready=0, disp_write=0, disp_data=00, disp_rs=0, disp_b8=0, disp_delay=0.
- State=INIT step 0, digit counter=0.
REQ-036 SHALL, when reset is asserted mid-transfer, drop disp_write immediately, discard the pending request, and rerun the full init sequence on release.

Verification
REQ-037 SHALL cover these directed scenarios (NUM_DIGITS=8 unless stated):
- Init: release rst_n; a disp_ready model drops ready for 5 cycles per write -> 8 transfers 30,30,30,20,28,06,0C,01 with disp_b8 0,0,0,0,1,1,1,1 and delays 10000000, 20000, 1000000, 20000, 20000, 20000, 20000, 1000000, then if_ready=1.
- Basic write: if_data=12ABCDEF, row 0, col 0, blank 0, clear 1 -> 01, 80, then rs=1 for 31 32 41 42 43 44 45 46, then if_ready=1.
- Blanked write: if_data=000000A5, row 1, col 4, blank 1, clear 0 -> C4, then six 0x20, 41, 35.
- Zero value: if_data=00000000, blank 1 -> seven 0x20 followed by 30.
- Busy and reset: a second if_write mid-DIGIT produces no extra transfer; rst_n low mid-DIGIT -> disp_write=0 the same cycle, init resequences, and the old request is lost.
- Parameter change: NUM_DIGITS=4 with if_data=BEEF, col 14 -> 8E, 42 45 45 46, with no re-addressing.
